// File: rtl/fft_bitrev_reorder_if.sv
// Streaming sample interface of the FFT bit-reversal reorder buffer.
// master drives input samples and consumes output samples; slave is the reorder block.
interface fft_bitrev_reorder_if #(
    parameter int DW = 16
);
    logic          valid_in;
    logic          sop_in;
    logic [DW-1:0] x_re;
    logic [DW-1:0] x_im;
    logic          in_ready;
    logic          valid_out;
    logic          sop_out;
    logic          eop_out;
    logic [DW-1:0] y_re;
    logic [DW-1:0] y_im;
    logic          frame_err;

    modport master (
        output valid_in, sop_in, x_re, x_im,
        input  in_ready, valid_out, sop_out, eop_out, y_re, y_im, frame_err
    );

    modport slave (
        input  valid_in, sop_in, x_re, x_im,
        output in_ready, valid_out, sop_out, eop_out, y_re, y_im, frame_err
    );
endinterface

// File: rtl/fft_bitrev_reorder.sv
// Ping-pong reorder buffer: bit-reversed FFT frames in, natural-order frames out.
// Optional macro FFT_SHIFT_EN swaps output halves (DC-centred fftshift order).
//
// state   | meaning
// --------+-----------------------------------------------------------------
// ST_IDLE | no frame being read; address 0 is issued as soon as rd_bank fills
// ST_READ | issuing read addresses rd_cnt=1..N-1 (0 again when gapless)
module fft_bitrev_reorder #(
    parameter int LOG2N = 8,
    parameter int DW    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    fft_bitrev_reorder_if.slave   bus
);
    localparam int N = 1 << LOG2N;
    localparam logic [LOG2N-1:0] CNT_MAX = LOG2N'(N - 1);

    typedef enum logic {ST_IDLE, ST_READ} state_t;

    logic [2*DW-1:0]  mem [2*N];
    logic [1:0]       full, full_nx;
    logic             wr_bank, rd_bank, rd_bank_nx;
    logic [LOG2N-1:0] wr_cnt, rd_cnt, rd_cnt_nx;
    logic [LOG2N-1:0] wr_addr, rd_addr;
    logic             accept, wr_en, wr_last;
    logic             rd_en, rd_free;
    state_t           state, state_nx;

    logic             valid_q, sop_q, eop_q, err_q;
    logic [DW-1:0]    y_re_q, y_im_q;

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
        logic [LOG2N-1:0] r;
        for (int i = 0; i < LOG2N; i++) r[i] = a[LOG2N-1-i];
        return r;
    endfunction

    // in_ready comes from registered flags only, so a bank freed this cycle is writable next cycle
    assign bus.in_ready = !full[wr_bank];
    assign accept       = bus.valid_in && bus.in_ready;
    assign wr_en        = accept && (bus.sop_in || (wr_cnt != '0));
    assign wr_last      = accept && !bus.sop_in && (wr_cnt == CNT_MAX);
    assign wr_addr      = bus.sop_in ? '0 : bitrev(wr_cnt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt  <= '0;
            wr_bank <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            err_q <= accept && bus.sop_in && (wr_cnt != '0);
            if (accept) begin
                if (bus.sop_in) begin
                    wr_cnt <= LOG2N'(1);
                end else if (wr_cnt != '0) begin
                    if (wr_last) begin
                        wr_cnt  <= '0;
                        wr_bank <= ~wr_bank;
                    end else begin
                        wr_cnt <= wr_cnt + 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[{wr_bank, wr_addr}] <= {bus.x_re, bus.x_im};
    end

`ifdef FFT_SHIFT_EN
    assign rd_addr = {~rd_cnt[LOG2N-1], rd_cnt[LOG2N-2:0]};
`else
    assign rd_addr = rd_cnt;
`endif

    always_comb begin
        state_nx   = state;
        rd_cnt_nx  = rd_cnt;
        rd_bank_nx = rd_bank;
        rd_en      = 1'b0;
        rd_free    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (full[rd_bank]) begin
                    rd_en     = 1'b1;
                    rd_cnt_nx = rd_cnt + 1'b1;
                    state_nx  = ST_READ;
                end
            end
            ST_READ: begin
                rd_en = 1'b1;
                if (rd_cnt == CNT_MAX) begin
                    rd_free    = 1'b1;
                    rd_bank_nx = ~rd_bank;
                    rd_cnt_nx  = '0;
                    state_nx   = full[~rd_bank] ? ST_READ : ST_IDLE;
                end else begin
                    rd_cnt_nx = rd_cnt + 1'b1;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        full_nx = full;
        if (rd_free) full_nx[rd_bank] = 1'b0;
        if (wr_last) full_nx[wr_bank] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            rd_cnt  <= '0;
            rd_bank <= 1'b0;
            full    <= '0;
        end else begin
            state   <= state_nx;
            rd_cnt  <= rd_cnt_nx;
            rd_bank <= rd_bank_nx;
            full    <= full_nx;
        end
    end

    // The RAM read register doubles as the output register to hold the T+2 latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            y_re_q  <= '0;
            y_im_q  <= '0;
        end else begin
            valid_q <= rd_en;
            sop_q   <= rd_en && (rd_cnt == '0);
            eop_q   <= rd_en && (rd_cnt == CNT_MAX);
            if (rd_en) {y_re_q, y_im_q} <= mem[{rd_bank, rd_addr}];
        end
    end

    assign bus.valid_out = valid_q;
    assign bus.sop_out   = sop_q;
    assign bus.eop_out   = eop_q;
    assign bus.y_re      = y_re_q;
    assign bus.y_im      = y_im_q;
    assign bus.frame_err = err_q;
endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Directed scoreboard bench for fft_bitrev_reorder at LOG2N=4, DW=16.
// Expected order follows FFT_SHIFT_EN when the macro is defined for the build.
module tb_fft_bitrev_reorder;
    localparam int LOG2N = 4;
    localparam int DW    = 16;
    localparam int N     = 1 << LOG2N;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fft_bitrev_reorder_if #(.DW(DW)) bus ();

    fft_bitrev_reorder #(.LOG2N(LOG2N), .DW(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [DW-1:0] re;
        logic [DW-1:0] im;
        logic          sop;
        logic          eop;
        int            cyc;
    } exp_t;

    exp_t          sb[$];
    exp_t          mon_e;
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            err_pulses = 0;
    int            err_base;
    logic [DW-1:0] fre [N];
    logic [DW-1:0] fim [N];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int brev(input int k);
        int r = 0;
        for (int i = 0; i < LOG2N; i++) r |= ((k >> i) & 1) << (LOG2N - 1 - i);
        return r;
    endfunction

    always @(negedge clk) begin
        if (bus.frame_err === 1'b1) err_pulses++;
        if (bus.valid_out === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_valid_out", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("y_re", 32'(bus.y_re), 32'(mon_e.re));
                check("y_im", 32'(bus.y_im), 32'(mon_e.im));
                check("sop_out", 32'(bus.sop_out), 32'(mon_e.sop));
                check("eop_out", 32'(bus.eop_out), 32'(mon_e.eop));
                check("out_cycle", 32'(cyc), 32'(mon_e.cyc));
            end
        end else begin
            check("sop_eop_without_valid", 32'({bus.sop_out, bus.eop_out}), 32'd0);
        end
    end

    // Sends fre/fim as one frame in bit-reversed order, optionally with random idle gaps
    task automatic send_frame(input bit gaps);
        int k = 0;
        int last_cyc = 0;
        int b;
        while (k < N) begin
            if (gaps && ($urandom_range(0, 1) == 1)) begin
                bus.valid_in = 1'b0;
                bus.sop_in   = 1'b0;
                @(posedge clk); #1;
            end else begin
                bus.valid_in = 1'b1;
                bus.sop_in   = (k == 0);
                bus.x_re     = fre[brev(k)];
                bus.x_im     = fim[brev(k)];
                @(negedge clk);
                check("in_ready", 32'(bus.in_ready), 32'd1);
                last_cyc = cyc;
                @(posedge clk); #1;
                k++;
            end
        end
        bus.valid_in = 1'b0;
        bus.sop_in   = 1'b0;
        for (int j = 0; j < N; j++) begin
`ifdef FFT_SHIFT_EN
            b = j ^ (N / 2);
`else
            b = j;
`endif
            sb.push_back('{fre[b], fim[b], (j == 0), (j == N - 1), last_cyc + 2 + j});
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
        check("drain_timeout", 32'(sb.size()), 32'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid_out"}, 32'(bus.valid_out), 32'd0);
        check({tag, "_sop_out"},   32'(bus.sop_out),   32'd0);
        check({tag, "_eop_out"},   32'(bus.eop_out),   32'd0);
        check({tag, "_y_re"},      32'(bus.y_re),      32'd0);
        check({tag, "_y_im"},      32'(bus.y_im),      32'd0);
        check({tag, "_frame_err"}, 32'(bus.frame_err), 32'd0);
        check({tag, "_in_ready"},  32'(bus.in_ready),  32'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        bus.valid_in = 1'b0;
        bus.sop_in   = 1'b0;
        bus.x_re     = '0;
        bus.x_im     = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // single frame, value = bin
        for (int b = 0; b < N; b++) begin fre[b] = 16'(b); fim[b] = 16'(b); end
        send_frame(1'b0);
        drain();
        check("err_single", 32'(err_pulses), 32'd0);

        // three back-to-back frames
        for (int f = 0; f < 3; f++) begin
            for (int b = 0; b < N; b++) begin
                fre[b] = 16'(16 * f + b);
                fim[b] = 16'hA000 | 16'(16 * f + b);
            end
            send_frame(1'b0);
        end
        drain();

        // partial frame of 9 samples, then sop restarts a full frame
        err_base = err_pulses;
        for (int k = 0; k < 9; k++) begin
            bus.valid_in = 1'b1;
            bus.sop_in   = (k == 0);
            bus.x_re     = 16'h5555 + 16'(k);
            bus.x_im     = 16'h6666 + 16'(k);
            @(posedge clk); #1;
        end
        for (int b = 0; b < N; b++) begin fre[b] = 16'h0100 + 16'(b); fim[b] = 16'h0200 + 16'(b); end
        send_frame(1'b0);
        drain();
        check("frame_err_pulses", 32'(err_pulses - err_base), 32'd1);

        // sample without sop after reset is dropped
        do_reset();
        err_base = err_pulses;
        bus.valid_in = 1'b1;
        bus.sop_in   = 1'b0;
        bus.x_re     = 16'h7FFF;
        bus.x_im     = 16'h7FFF;
        @(posedge clk); #1;
        bus.valid_in = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        for (int b = 0; b < N; b++) begin fre[b] = 16'h1000 + 16'(b); fim[b] = ~(16'h1000 + 16'(b)); end
        send_frame(1'b0);
        drain();
        check("err_after_drop", 32'(err_pulses - err_base), 32'd0);

        // random input gaps, bit-exact negative values
        for (int b = 0; b < N; b++) begin fre[b] = 16'h8000 + 16'(b); fim[b] = 16'h800F - 16'(b); end
        send_frame(1'b1);
        drain();

        // reset in the middle of a readout, then a clean frame
        for (int b = 0; b < N; b++) begin fre[b] = 16'h2000 + 16'(b); fim[b] = 16'h2100 + 16'(b); end
        send_frame(1'b0);
        repeat (4) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        sb.delete();
        check_reset_outputs("mid_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int b = 0; b < N; b++) begin fre[b] = 16'h3000 + 16'(b); fim[b] = 16'h3100 + 16'(b); end
        send_frame(1'b0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fft_bitrev_reorder.md
Name: fft_bitrev_reorder

Overview:
- Parametrised streaming reorder buffer placed directly after the FFT core (fft_256 and its successors).
- Accepts frames of N = 2^LOG2N complex samples in bit-reversed index order, framed by sop_in/valid_in.
- Emits each frame in natural order (bin 0..N-1) with sop_out/eop_out framing.
- Ping-pong double buffer: full throughput with back-to-back frames; any LOG2N and sample width.

Parameters:
- LOG2N, 8, log2 of frame length N (2..12); N=256 matches fft_256.
- DW, 16, bit width of each real/imag component (signed, two's complement).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- valid_in  in  1  input sample valid.
- sop_in  in  1  start of frame; qualified by valid_in; marks bit-reversed index 0.
- x_re  in  DW  input real part.
- x_im  in  DW  input imag part.
- in_ready  out  1  write bank available; a sample is accepted only when valid_in && in_ready.
- valid_out  out  1  output sample valid.
- sop_out  out  1  first output sample of frame.
- eop_out  out  1  last output sample of frame.
- y_re  out  DW  output real part.
- y_im  out  DW  output imag part.
- frame_err  out  1  one-cycle pulse: partial frame discarded.

Behaviour:
- Reset (async, rst_n=0): all outputs 0 except in_ready=1. Both banks empty, wr_bank=0, rd_bank=0, wr_cnt=0, reader idle. Buffer RAM contents are don't-care.
- Storage: two banks of N x 2*DW, synchronous-read RAM.
- Write side:
  - Accepted sample with sop_in=1 starts a new frame: written to index 0; wr_cnt becomes 1.
  - Accepted sample with sop_in=0 while wr_cnt>0 is written at address bitrev(wr_cnt) (LOG2N-bit reversal); wr_cnt++.
  - Accepted sample with sop_in=0 while wr_cnt==0: dropped silently; writer waits for sop.
  - sop_in while wr_cnt>0: partial frame discarded; new frame starts at index 0; frame_err pulses the following cycle.
  - Write of index wr_cnt=N-1: bank marked full, wr_bank toggles, wr_cnt=0.
  - in_ready = !full[wr_bank].
- Read side FSM:
  - IDLE: go to READ when full[rd_bank].
  - READ: issue addresses rd_cnt=0..N-1, one per cycle, no output backpressure.
  - On rd_cnt=N-1: clear full[rd_bank], toggle rd_bank. Return to IDLE, or stay in READ at rd_cnt=0 if the other bank is already full (gapless output).
- Output timing:
  - Data, valid_out, sop_out and eop_out are registered from RAM output.
  - With the last sample of a frame accepted in cycle T, sop_out is high in cycle T+2.
  - N consecutive valid_out cycles follow; eop_out is high with bin N-1.
  - sop_out and eop_out are only high with valid_out.
- Throughput: continuous input at 1 sample/cycle never deasserts in_ready.
  - Bank freed at cycle 2N-1 is writable at 2N.
  - Simultaneous free and re-fill of the same bank in one cycle: free wins first; the write is still accepted, since in_ready is computed from registered full flags.
- Gaps: valid_in gaps mid-frame are allowed; wr_cnt holds.
- Samples are passed through bit-exact; no arithmetic.

Optional Feature:
- Macro FFT_SHIFT_EN.
- Defined: read address = {~rd_cnt[LOG2N-1], rd_cnt[LOG2N-2:0]}. Output order is bin N/2..N-1 then 0..N/2-1 (fftshift, DC centred). sop_out/eop_out are still on the first/last output cycle.
- Undefined: natural order, bin 0 first. No extra ports or latency either way.

Test Plan:
- LOG2N=4, DW=16, one frame: x_re=x_im=bitrev(k) for k=0..15, sop_in on k=0 -> sop_out at T+2; y_re=y_im=0,1,...,15; eop_out with 15; frame_err=0.
- Three back-to-back frames, continuous valid_in, frame f value = 16*f+bin -> in_ready stays 1; 48 consecutive valid_out; sop_out every 16 cycles; values 0..47 in order.
- sop_in asserted at input sample 9, then a full 16-sample frame -> frame_err pulses once; only the second frame is output.
- Sample without sop after reset (valid_in=1, sop_in=0, x_re=0x7FFF) -> dropped; no valid_out; then a normal frame outputs correctly.
- Random valid_in gaps (50% duty), values 0x8000..0x800F -> bit-exact natural-order output. rst_n pulsed low mid-readout -> all outputs 0 immediately, in_ready=1, next frame correct.
- FFT_SHIFT_EN defined, same frame as first test -> y_re order 8..15,0..7; sop_out on 8, eop_out on 7.
